// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   Shares one OBI-style memory port between instruction fetch (requester 0)
//   and load/store (requester 1). Data normally wins. The instruction side is
//   forced to win after MAX_WAIT consecutive lost cycles. An ungranted
//   selection is locked until the memory grants it. Issued transaction IDs are
//   kept in an in-order FIFO, so each response returns to its originator.
//
// Ports
//   CLK, RST_N         clock, asynchronous active-low reset
//   instr_*            fetch request/grant and response (read-only requester)
//   data_*             load/store request/grant and response
//   bus_*              shared memory port (request, grant, response)
//   outstanding_o      issued transactions still awaiting a response
//   resp_unexpected_o  sticky: a response arrived with nothing outstanding
module obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_WAIT        = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic [3:0]  outstanding_o,
    output logic        resp_unexpected_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    lock_state_t                state_q, state_d;
    logic                       lock_data_q, lock_data_d;
    logic [3:0]                 starve_q;
    logic [3:0]                 count_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] id_mem_q;
    logic                       unexp_q;

    logic     full, empty, win_data, push, pop, head_id;
    bus_cmd_t cmd;

    assign full  = (count_q == 4'(MAX_OUTSTANDING));
    assign empty = (count_q == 4'd0);

    // Gated with RST_N so the port stays quiet while reset is held, even with
    // requests pending. No pop bypass: a full FIFO blocks issue outright.
    assign bus_req_o = RST_N & (instr_req_i | data_req_i) & ~full;

    // Winner select: a locked selection overrides arbitration.
    always_comb begin
        win_data = 1'b0;
        if (state_q == LOCKED)
            win_data = lock_data_q;
        else if (data_req_i && !(instr_req_i && starve_q == 4'(MAX_WAIT)))
            win_data = 1'b1;
    end

    // Lock FSM
    always_comb begin
        state_d     = state_q;
        lock_data_d = lock_data_q;
        case (state_q)
            UNLOCKED: if (bus_req_o && !bus_gnt_i) begin
                state_d     = LOCKED;
                lock_data_d = win_data;
            end
            LOCKED:   if (bus_gnt_i) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= UNLOCKED;
            lock_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_data_q <= lock_data_d;
        end
    end

    // Bus command mux
    always_comb begin
        cmd = '0;
        if (bus_req_o) begin
            if (win_data) cmd = '{data_we_i, data_be_i, data_addr_i, data_wdata_i};
            else          cmd = '{1'b0, 4'hF, instr_addr_i, 32'h0};
        end
    end

    assign bus_we_o    = cmd.we;
    assign bus_be_o    = cmd.be;
    assign bus_addr_o  = cmd.addr;
    assign bus_wdata_o = cmd.wdata;

    assign push        = bus_req_o & bus_gnt_i;
    assign instr_gnt_o = push & ~win_data;
    assign data_gnt_o  = push & win_data;

    // Response routing from FIFO head
    assign pop            = bus_rvalid_i & ~empty;
    assign head_id        = id_mem_q[rd_ptr_q];
    assign instr_rvalid_o = pop & ~head_id;
    assign data_rvalid_o  = pop & head_id;
    assign instr_err_o    = instr_rvalid_o & bus_err_i;
    assign data_err_o     = data_rvalid_o & bus_err_i;
    assign instr_rdata_o  = bus_rdata_i;
    assign data_rdata_o   = bus_rdata_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // In-order ID FIFO
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            id_mem_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                id_mem_q[wr_ptr_q] <= win_data;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Starvation counter and unexpected-response flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_q <= '0;
            unexp_q  <= 1'b0;
        end else begin
            if (!instr_req_i || instr_gnt_o)  starve_q <= '0;
            else if (starve_q != 4'(MAX_WAIT)) starve_q <= starve_q + 4'd1;
            if (bus_rvalid_i && empty) unexp_q <= 1'b1;
        end
    end

    assign outstanding_o     = count_q;
    assign resp_unexpected_o = unexp_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;

    logic        CLK = 1'b0, RST_N;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;
    logic [3:0]  outstanding_o;
    logic        resp_unexpected_o;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2), .MAX_WAIT(3)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .outstanding_o(outstanding_o), .resp_unexpected_o(resp_unexpected_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_i(input logic r, input logic [31:0] a);
        instr_req_i = r; instr_addr_i = a;
    endtask

    task automatic set_d(input logic r, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        data_req_i = r; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = wd;
    endtask

    task automatic set_b(input logic gnt, input logic rv, input logic [31:0] rd, input logic err);
        bus_gnt_i = gnt; bus_rvalid_i = rv; bus_rdata_i = rd; bus_err_i = err;
    endtask

    task automatic expect_rsp(input logic id, input logic [31:0] rd, input logic err);
        rsp_t e;
        e.id = id; e.rdata = rd; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Monitor: each routed response is matched against the scoreboard head.
    always @(negedge CLK) begin
        if (instr_rvalid_o || data_rvalid_o) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rsp_extra: got rvalid i=%0b d=%0b, expected none",
                         instr_rvalid_o, data_rvalid_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_route", {30'd0, data_rvalid_o, instr_rvalid_o}, mon_e.id ? 32'd2 : 32'd1);
                chk("rsp_rdata", mon_e.id ? data_rdata_o : instr_rdata_o, mon_e.rdata);
                chk("rsp_err", mon_e.id ? data_err_o : instr_err_o, {31'd0, mon_e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        set_i(1'b1, 32'h100);
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_b(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_unexpected", resp_unexpected_o, 0);
        chk("rst_instr_gnt", instr_gnt_o, 0);
        set_i(1'b0, 32'h0);
        #1 RST_N = 1'b1;
        tick();

        // 1: single fetch, response next cycle
        set_i(1'b1, 32'h100); set_b(1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("t1_igntt", instr_gnt_o, 1);
        chk("t1_addr", bus_addr_o, 32'h100);
        chk("t1_be", bus_be_o, 4'hF);
        chk("t1_we", bus_we_o, 0);
        chk("t1_dgnt", data_gnt_o, 0);
        tick();
        chk("t1_out1", outstanding_o, 1);
        set_i(1'b0, 32'h0); set_b(1'b0, 1'b1, 32'h13, 1'b0); expect_rsp(1'b0, 32'h13, 1'b0); #1;
        chk("t1_irvalid", instr_rvalid_o, 1);
        tick();
        chk("t1_out0", outstanding_o, 0);

        // 2: both requesting; data wins until the starve limit forces instr
        set_i(1'b1, 32'h104); set_d(1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF);
        set_b(1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("t2a_dgnt", data_gnt_o, 1);
        chk("t2a_igntt", instr_gnt_o, 0);
        chk("t2a_wdata", bus_wdata_o, 32'hDEADBEEF);
        chk("t2a_addr", bus_addr_o, 32'h2000);
        chk("t2a_we", bus_we_o, 1);
        tick();
        set_b(1'b1, 1'b1, 32'h11, 1'b0); expect_rsp(1'b1, 32'h11, 1'b0); #1;
        chk("t2b_dgnt", data_gnt_o, 1);
        tick();
        chk("t2b_out_same", outstanding_o, 1);
        set_b(1'b1, 1'b1, 32'h22, 1'b0); expect_rsp(1'b1, 32'h22, 1'b0); #1;
        chk("t2c_dgnt", data_gnt_o, 1);
        tick();
        set_b(1'b1, 1'b1, 32'h33, 1'b0); expect_rsp(1'b1, 32'h33, 1'b0); #1;
        chk("t2d_igntt", instr_gnt_o, 1);
        chk("t2d_dgnt", data_gnt_o, 0);
        chk("t2d_addr", bus_addr_o, 32'h104);
        chk("t2d_wdata", bus_wdata_o, 0);
        chk("t2d_we", bus_we_o, 0);
        tick();
        set_i(1'b0, 32'h0); set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_b(1'b0, 1'b1, 32'h44, 1'b0); expect_rsp(1'b0, 32'h44, 1'b0);
        tick();
        chk("t2_out0", outstanding_o, 0);

        // 3: ungranted instr selection stays locked while data appears
        set_i(1'b1, 32'h200); set_b(1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("t3c1_req", bus_req_o, 1);
        chk("t3c1_addr", bus_addr_o, 32'h200);
        tick();
        set_d(1'b1, 1'b0, 4'h3, 32'h3000, 32'h0); #1;
        chk("t3c2_addr", bus_addr_o, 32'h200);
        chk("t3c2_dgnt", data_gnt_o, 0);
        chk("t3c2_be", bus_be_o, 4'hF);
        tick();
        chk("t3c3_addr", bus_addr_o, 32'h200);
        chk("t3c3_dgnt", data_gnt_o, 0);
        tick();
        set_b(1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("t3c4_igntt", instr_gnt_o, 1);
        chk("t3c4_dgnt", data_gnt_o, 0);
        tick();
        set_i(1'b0, 32'h0); #1;
        chk("t3c5_dgnt", data_gnt_o, 1);
        chk("t3c5_addr", bus_addr_o, 32'h3000);
        chk("t3c5_be", bus_be_o, 4'h3);
        tick();

        // 4: full FIFO blocks issue, including on a popping cycle
        chk("t4_out2", outstanding_o, 2);
        set_i(1'b1, 32'h204); #1;
        chk("t4_full_req", bus_req_o, 0);
        chk("t4_full_ignt", instr_gnt_o, 0);
        chk("t4_full_dgnt", data_gnt_o, 0);
        chk("t4_full_addr", bus_addr_o, 0);
        tick();
        set_b(1'b1, 1'b1, 32'h55, 1'b0); expect_rsp(1'b0, 32'h55, 1'b0); #1;
        chk("t4_nobypass", bus_req_o, 0);
        tick();
        chk("t4_out1", outstanding_o, 1);
        set_b(1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("t4_req_again", bus_req_o, 1);
        chk("t4_dgnt", data_gnt_o, 1);
        chk("t4_ignt", instr_gnt_o, 0);
        tick();
        set_i(1'b0, 32'h0); set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_b(1'b0, 1'b1, 32'h66, 1'b0); expect_rsp(1'b1, 32'h66, 1'b0);
        tick();
        set_b(1'b0, 1'b1, 32'h77, 1'b0); expect_rsp(1'b1, 32'h77, 1'b0);
        tick();
        chk("t4_out0", outstanding_o, 0);

        // 5: instr, data, instr; error on the data response
        set_i(1'b1, 32'h300); set_b(1'b1, 1'b0, 32'h0, 1'b0); #1;
        chk("t5a_ignt", instr_gnt_o, 1);
        tick();
        set_i(1'b0, 32'h0); set_d(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
        set_b(1'b1, 1'b1, 32'hA0, 1'b0); expect_rsp(1'b0, 32'hA0, 1'b0); #1;
        chk("t5b_dgnt", data_gnt_o, 1);
        tick();
        set_i(1'b1, 32'h304); set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_b(1'b1, 1'b1, 32'hB0, 1'b1); expect_rsp(1'b1, 32'hB0, 1'b1); #1;
        chk("t5c_ignt", instr_gnt_o, 1);
        chk("t5c_derr", data_err_o, 1);
        chk("t5c_irvalid", instr_rvalid_o, 0);
        chk("t5c_ierr", instr_err_o, 0);
        tick();
        set_i(1'b0, 32'h0); set_b(1'b0, 1'b1, 32'hC0, 1'b0); expect_rsp(1'b0, 32'hC0, 1'b0);
        tick();
        chk("t5_out0", outstanding_o, 0);

        // 6: unexpected response, then reset mid-transaction
        set_b(1'b0, 1'b1, 32'hEE, 1'b0); #1;
        chk("t6_unexp_before", resp_unexpected_o, 0);
        tick();
        chk("t6_unexp_set", resp_unexpected_o, 1);
        chk("t6_out_unchanged", outstanding_o, 0);
        set_i(1'b1, 32'h400); set_b(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        set_b(1'b0, 1'b0, 32'h0, 1'b0); #1;
        chk("t6_out1", outstanding_o, 1);
        chk("t6_req_pre", bus_req_o, 1);
        RST_N = 1'b0; #1;
        chk("t6_rst_req", bus_req_o, 0);
        chk("t6_rst_ignt", instr_gnt_o, 0);
        chk("t6_rst_out", outstanding_o, 0);
        chk("t6_rst_unexp", resp_unexpected_o, 0);
        chk("t6_rst_addr", bus_addr_o, 0);
        set_i(1'b0, 32'h0);
        tick();
        RST_N = 1'b1;
        tick();
        set_b(1'b0, 1'b1, 32'h99, 1'b0); #1;
        chk("t6_drop_irvalid", instr_rvalid_o, 0);
        chk("t6_drop_drvalid", data_rvalid_o, 0);
        tick();
        chk("t6_unexp_post", resp_unexpected_o, 1);
        set_b(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        @(negedge CLK); #1;
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
